ioctl_rom_sink: RTL

- Receiving end of the hps_io ioctl download stream for ROM images (index 0).
- Decodes each byte's address into a target ROM region and presents one registered write per byte to the core's ROM memories.
- Back-pressures the HPS through ioctl_wait while the target port is busy.
- Tracks completion, byte count, overrun and a running checksum; sits between hps_io and the dn_* ports of the game top.

---
 rtl/rom_sink_pkg.sv | 55 +++++
 rtl/rom_skid_buf.sv | 47 ++++
 rtl/ioctl_rom_sink.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rom_sink_pkg.sv
// Shared types, the ROM region map and the FSM state encoding for the ioctl ROM sink.
// Each region occupies one 8 KiB granule; granules not listed below are unmapped.
package rom_sink_pkg;

  localparam int PKG_ADDR_W = 17;
  localparam int PKG_GRAN_W = 13;
  localparam int PKG_NREG   = 6;
  localparam int GIDX_W     = PKG_ADDR_W - PKG_GRAN_W;

  // Six mapped granules make up a complete image.
  localparam int unsigned IMAGE_BYTES = 6 * (1 << PKG_GRAN_W);

  typedef enum logic [2:0] {
    MAIN0 = 3'd0,
    MAIN1 = 3'd1,
    SND   = 3'd2,
    CHR   = 3'd3,
    OBJ   = 3'd4,
    BG    = 3'd5
  } region_id_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STALL,
    ST_DONE
  } st_t;

  typedef struct packed {
    logic                  valid;
    region_id_t            id;
    logic [PKG_ADDR_W-1:0] base;
  } region_t;

  function automatic region_t region_lookup(input logic [GIDX_W-1:0] gran);
    region_t r;
    r.valid = 1'b1;
    r.id    = MAIN0;
    r.base  = {gran, {PKG_GRAN_W{1'b0}}};
    case (gran)
      4'd0:    r.id = MAIN0;
      4'd1:    r.id = MAIN1;
      4'd2:    r.id = SND;
      4'd6:    r.id = CHR;
      4'd7:    r.id = OBJ;
      4'd8:    r.id = BG;
      default: begin
        r.valid = 1'b0;
        r.base  = '0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rom_skid_buf.sv
// One-entry skid register that parks a byte while the ROM port is busy and
// drives the HPS back-pressure line.
module rom_skid_buf
  import rom_sink_pkg::*;
#(
  parameter int ADDR_W = PKG_ADDR_W
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              push,
  input  logic              tgt_busy,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  region_id_t        wr_id,
  output logic              valid,
  output logic              pop,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_data,
  output region_id_t        buf_id,
  output logic              ioctl_wait
);

  assign pop = valid && !tgt_busy;

  // Wait rises combinationally with the strobe so hps_io holds its next byte,
  // and drops in the very cycle the parked byte is released.
  assign ioctl_wait = push || (valid && tgt_busy);

  // NOTE: the payload registers are reset as well; they are a handful of flops,
  // and resetting them keeps the outputs deterministic after a mid-load reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      valid    <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      buf_id   <= MAIN0;
    end else if (push) begin
      valid    <= 1'b1;
      buf_addr <= wr_addr;
      buf_data <= wr_data;
      buf_id   <= wr_id;
    end else if (pop) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/ioctl_rom_sink.sv
// Receives the hps_io ROM download, routes each byte to its region port with a
// one-cycle registered write, and tracks completion, count, checksum and overrun.
module ioctl_rom_sink
  import rom_sink_pkg::*;
#(
  parameter int         ADDR_W    = PKG_ADDR_W,
  parameter int         GRAN_W    = PKG_GRAN_W,
  parameter int         NREG      = PKG_NREG,
  parameter logic [7:0] ROM_INDEX = 8'd0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              tgt_busy,
  output logic [NREG-1:0]   rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic              rom_loaded,
  output logic              core_hold,
  output logic [ADDR_W:0]   byte_cnt,
  output logic [15:0]       checksum,
  output logic              overrun
);

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] IMG_CNT = (ADDR_W+1)'(IMAGE_BYTES);

  st_t               state;
  logic              active, active_q;
  region_t           hit;
  logic              in_map, accept_wr, direct, push;
  logic              skid_valid, skid_pop;
  logic [ADDR_W-1:0] skid_addr, offset;
  logic [7:0]        skid_data;
  region_id_t        skid_id;
  logic              wr_fire;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  region_id_t        wr_id;
  logic              done_ok;

  assign active    = ioctl_download && (ioctl_index == ROM_INDEX);
  assign hit       = region_lookup(ioctl_addr[ADDR_W-1:GRAN_W]);
  assign in_map    = hit.valid && (ioctl_addr[24:ADDR_W] == '0);
  assign offset    = ioctl_addr[ADDR_W-1:0] - hit.base;
  assign accept_wr = ioctl_wr && active && (state == ST_LOAD || state == ST_STALL);
  assign direct    = (state == ST_LOAD) && accept_wr && in_map && !tgt_busy;
  // A byte landing on the drain cycle re-fills the skid while the parked one goes out.
  assign push      = accept_wr && in_map && ((state == ST_LOAD) ? tgt_busy : skid_pop);
  assign done_ok   = (byte_cnt == IMG_CNT) && !overrun;

  rom_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .push       (push),
    .tgt_busy   (tgt_busy),
    .wr_addr    (offset),
    .wr_data    (ioctl_dout),
    .wr_id      (hit.id),
    .valid      (skid_valid),
    .pop        (skid_pop),
    .buf_addr   (skid_addr),
    .buf_data   (skid_data),
    .buf_id     (skid_id),
    .ioctl_wait (ioctl_wait)
  );

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    wr_fire = skid_pop || direct;
    wr_addr = offset;
    wr_data = ioctl_dout;
    wr_id   = hit.id;
    if (skid_pop) begin
      wr_addr = skid_addr;
      wr_data = skid_data;
      wr_id   = skid_id;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every branch
  // below sees the pre-edge values of byte_cnt, overrun and state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      active_q   <= 1'b0;
      rom_we     <= '0;
      rom_addr   <= '0;
      rom_data   <= '0;
      rom_loaded <= 1'b0;
      core_hold  <= 1'b1;
      byte_cnt   <= '0;
      checksum   <= '0;
      overrun    <= 1'b0;
    end else begin
      active_q <= active;
      rom_we   <= '0;

      if (wr_fire) begin
        rom_we   <= NREG'(1) << wr_id;
        rom_addr <= wr_addr;
        rom_data <= wr_data;
        checksum <= checksum + {8'h00, wr_data};
        if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + 1'b1;
      end

      if (accept_wr && !in_map) overrun <= 1'b1;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (active && !active_q) begin
            state      <= ST_LOAD;
            byte_cnt   <= '0;
            checksum   <= '0;
            overrun    <= 1'b0;
            rom_loaded <= 1'b0;
            core_hold  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (push) begin
            state <= ST_STALL;
          end else if (!active) begin
            state      <= ST_DONE;
            rom_loaded <= done_ok;
            core_hold  <= !done_ok;
          end
        end
        ST_STALL: begin
          // The download end is handled from LOAD, after the parked byte has been counted.
          if (skid_pop && !push) state <= ST_LOAD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_no_wr_during_wait: assert property (
    @(posedge clk_sys) disable iff (!reset_n) !(ioctl_wr && active && skid_valid && tgt_busy)
  );

endmodule
